// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm trigger block: field widths and FSM encoding.
package alarm_pkg;

  localparam int unsigned HOUR_W = 5;   // hour field, 0..23
  localparam int unsigned MIN_W  = 6;   // minute field, 0..59
  localparam int unsigned SECT_W = 9;   // second timer, 1..511
  localparam int unsigned CNT_W  = 2;   // snooze counter, 0..3

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

endpackage

// File: rtl/alarm_sec_timer.sv
// Loadable second down-counter shared by the ring and snooze phases.
// Ports:
//   clock, reset      system clock, async active-high reset
//   load, load_val    load the counter (load beats tick)
//   tick              decrement request (one per second)
//   expire_c          tick arriving while the count is 1
module alarm_sec_timer
  import alarm_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [SECT_W-1:0] load_val,
  input  logic              tick,
  output logic              expire_c
);

  logic [SECT_W-1:0] r_count;

  // Counter saturates at zero; it is only refreshed by a load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (tick && (r_count != '0)) begin
      r_count <= r_count - SECT_W'(1);
    end
  end

  assign expire_c = tick & (r_count == SECT_W'(1));

endmodule

// File: rtl/alarm_trigger.sv
// Alarm trigger: compares current time against the stored alarm time and
// runs the ring / timeout / snooze / stop sequence driving the buzzer.
// Optional snooze support is built only when ALARM_SNOOZE_EN is defined;
// otherwise snooze_btn is ignored and snoozing / snooze_cnt stay 0.
// Ports:
//   clock, reset                 system clock, async active-high reset
//   tick_1hz                     one-clock pulse per second
//   time_hour, time_min          running time
//   alarm_hour, alarm_min        stored alarm time
//   alarm_on                     alarm armed (level)
//   stop_btn, snooze_btn         single-cycle debounced button pulses
//   buzzer                       beep drive, alternate seconds while ringing
//   ringing, snoozing            state indicators
//   snooze_cnt                   snoozes used in the current alarm event
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned SNOOZE_S       = 300,
  parameter int unsigned MAX_SNOOZE     = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic [HOUR_W-1:0] time_hour,
  input  logic [MIN_W-1:0]  time_min,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic [MIN_W-1:0]  alarm_min,
  input  logic              alarm_on,
  input  logic              stop_btn,
  input  logic              snooze_btn,
  output logic              buzzer,
  output logic              ringing,
  output logic              snoozing,
  output logic [CNT_W-1:0]  snooze_cnt
);

  state_t            r_state;
  state_t            w_next;
  logic              r_match_d;
  logic              r_beep_phase;
  logic              w_match;
  logic              w_trigger;
  logic              w_beep_next;
  logic [CNT_W-1:0]  w_snz_cnt_next;
  logic              w_load;
  logic [SECT_W-1:0] w_load_val;
  logic              w_tick;
  logic              w_expire;
  logic              w_snz_press;

  // Rising edge of the match gives one trigger per matching minute.
  assign w_match   = alarm_on & (time_hour == alarm_hour) & (time_min == alarm_min);
  assign w_trigger = w_match & ~r_match_d;

`ifdef ALARM_SNOOZE_EN
  // Snooze only acts while ringing; in SNOOZE it is ignored and does not drop a tick.
  assign w_snz_press = snooze_btn & (r_state == ST_RINGING);
`else
  logic w_unused_snz;
  assign w_snz_press  = 1'b0;
  assign w_unused_snz = ^{snooze_btn, SECT_W'(SNOOZE_S), CNT_W'(MAX_SNOOZE)};
`endif

  // A button press in the same cycle wins over the tick, so the tick is dropped.
  assign w_tick = tick_1hz & alarm_on & ~stop_btn & ~w_snz_press & (r_state != ST_IDLE);

  alarm_sec_timer u_sec_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .tick     (w_tick),
    .expire_c (w_expire)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, timer load and event bookkeeping.
  always_comb begin
    w_next         = r_state;
    w_load         = 1'b0;
    w_load_val     = SECT_W'(RING_TIMEOUT_S);
    w_beep_next    = r_beep_phase;
    w_snz_cnt_next = snooze_cnt;

    if (!alarm_on) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            w_next      = ST_RINGING;
            w_load      = 1'b1;
            w_beep_next = 1'b1;
          end
        end
        ST_RINGING: begin
          if (stop_btn) begin
            w_next = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
          end else if (w_snz_press) begin
            if (snooze_cnt < CNT_W'(MAX_SNOOZE)) begin
              w_next         = ST_SNOOZE;
              w_load         = 1'b1;
              w_load_val     = SECT_W'(SNOOZE_S);
              w_snz_cnt_next = snooze_cnt + CNT_W'(1);
            end else begin
              w_next = ST_IDLE;
            end
`endif
          end else if (w_tick) begin
            w_beep_next = ~r_beep_phase;
            if (w_expire) begin
              w_next = ST_IDLE;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (stop_btn) begin
            w_next = ST_IDLE;
          end else if (w_expire) begin
            w_next      = ST_RINGING;
            w_load      = 1'b1;
            w_beep_next = 1'b1;
          end
        end
`endif
        default: begin
          w_next = ST_IDLE;
        end
      endcase
    end

    // Every return to IDLE closes the alarm event.
    if (w_next == ST_IDLE) begin
      w_snz_cnt_next = '0;
    end
  end

  // Registered outputs, aligned with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_match_d    <= 1'b0;
      r_beep_phase <= 1'b0;
      snooze_cnt   <= '0;
      ringing      <= 1'b0;
      buzzer       <= 1'b0;
      snoozing     <= 1'b0;
    end else begin
      r_match_d    <= w_match;
      r_beep_phase <= w_beep_next;
      snooze_cnt   <= w_snz_cnt_next;
      ringing      <= (w_next == ST_RINGING);
      buzzer       <= (w_next == ST_RINGING) & w_beep_next;
      snoozing     <= (w_next == ST_SNOOZE);
    end
  end

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed testbench for alarm_trigger; snooze sequences run when
// ALARM_SNOOZE_EN is defined, the snooze-ignored checks otherwise.
module tb_alarm_trigger;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic [4:0] time_hour;
  logic [5:0] time_min;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_on;
  logic       stop_btn;
  logic       snooze_btn;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [1:0] snooze_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  alarm_trigger dut (
    .clock      (clock),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .time_hour  (time_hour),
    .time_min   (time_min),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .alarm_on   (alarm_on),
    .stop_btn   (stop_btn),
    .snooze_btn (snooze_btn),
    .buzzer     (buzzer),
    .ringing    (ringing),
    .snoozing   (snoozing),
    .snooze_cnt (snooze_cnt)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic press_snooze();
    snooze_btn = 1'b1;
    step();
    snooze_btn = 1'b0;
  endtask

  task automatic press_stop();
    stop_btn = 1'b1;
    step();
    stop_btn = 1'b0;
  endtask

  // Leave the alarm minute, then re-enter it to produce a fresh trigger.
  task automatic arm();
    time_min = 6'd31;
    step();
    time_min = 6'd30;
    step();
  endtask

  // Expected vector is {ringing, buzzer, snoozing, snooze_cnt[1:0]}.
  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {ringing, buzzer, snoozing, snooze_cnt};
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed r/b/s/cnt=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    tick_1hz   = 1'b0;
    stop_btn   = 1'b0;
    snooze_btn = 1'b0;
    alarm_on   = 1'b1;
    alarm_hour = 5'd7;
    alarm_min  = 6'd30;
    time_hour  = 5'd7;
    time_min   = 6'd29;

    steps(2);
    chk("reset", 5'b00000);
    reset = 1'b0;
    step();
    chk("idle_0729", 5'b00000);

    // Match rises: ringing and first beep one clock later.
    time_min = 6'd30;
    step();
    chk("trigger", 5'b11000);
    tick();
    chk("beep_off", 5'b10000);
    tick();
    chk("beep_on", 5'b11000);
    ticks(57);
    chk("tick59", 5'b10000);
    tick();
    chk("timeout60", 5'b00000);
    steps(5);
    chk("no_retrigger_after_timeout", 5'b00000);

    // Stop after five ticks, then hold the matching minute.
    arm();
    chk("arm_stop_case", 5'b11000);
    ticks(5);
    chk("ring5", 5'b10000);
    press_stop();
    chk("stop", 5'b00000);
    ticks(50);
    chk("hold_no_retrigger", 5'b00000);

    // Alarm minute edits do not affect the current event.
    arm();
    alarm_min = 6'd45;
    ticks(3);
    chk("alarm_min_change", 5'b10000);
    alarm_min = 6'd30;
    step();
    chk("alarm_min_restore", 5'b10000);
    press_stop();
    chk("stop_after_edit", 5'b00000);

    // Disarm while ringing; re-arming inside the minute is a new rising match.
    arm();
    alarm_on = 1'b0;
    step();
    chk("disarm_ringing", 5'b00000);
    alarm_on = 1'b1;
    step();
    chk("rearm_retrigger", 5'b11000);

    // Stop beats snooze in the same cycle.
    stop_btn   = 1'b1;
    snooze_btn = 1'b1;
    step();
    stop_btn   = 1'b0;
    snooze_btn = 1'b0;
    chk("stop_beats_snooze", 5'b00000);

`ifdef ALARM_SNOOZE_EN
    arm();
    press_snooze();
    chk("snooze1", 5'b00101);
    ticks(299);
    chk("snooze1_299", 5'b00101);
    tick();
    chk("rering1", 5'b11001);
    press_snooze();
    chk("snooze2", 5'b00110);
    ticks(300);
    chk("rering2", 5'b11010);
    press_snooze();
    chk("snooze3", 5'b00111);
    ticks(300);
    chk("rering3", 5'b11011);
    press_snooze();
    chk("snooze4_stops", 5'b00000);

    // Tick dropped when snooze arrives with it; snooze reloads the full period.
    arm();
    tick();
    chk("pre_tick_snooze", 5'b10000);
    tick_1hz   = 1'b1;
    snooze_btn = 1'b1;
    step();
    tick_1hz   = 1'b0;
    snooze_btn = 1'b0;
    chk("tick_with_snooze", 5'b00101);
    press_snooze();
    chk("snooze_ignored_in_snooze", 5'b00101);
    ticks(299);
    chk("tick_snooze_299", 5'b00101);
    tick();
    chk("tick_snooze_rering", 5'b11001);

    // Disarm while snoozing.
    press_snooze();
    chk("snooze_before_disarm", 5'b00110);
    alarm_on = 1'b0;
    step();
    chk("disarm_snooze", 5'b00000);
    time_min = 6'd0;
    alarm_on = 1'b1;
    step();
    chk("rearm_off_minute", 5'b00000);
`else
    arm();
    press_snooze();
    chk("snooze_ignored", 5'b11000);
    tick_1hz   = 1'b1;
    snooze_btn = 1'b1;
    step();
    tick_1hz   = 1'b0;
    snooze_btn = 1'b0;
    chk("tick_with_snooze_kept", 5'b10000);
    ticks(58);
    chk("still_ringing_59", 5'b10000);
    tick();
    chk("timeout_no_snooze", 5'b00000);
`endif

    // Reset asserted between edges clears outputs immediately.
    arm();
    chk("arm_reset_case", 5'b11000);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset", 5'b00000);
    steps(2);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
